// File: rtl/dmux16_sched.sv
// dmux16_sched: routes a 16-bit input stream to one of two output holding registers
// (channel A / channel B), either alternating (round-robin, mode=0) or steered by
// in_sel (mode=1). Each channel is a single-entry buffer with valid/ready handshake.
//
// Ports:
//   clk, reset              - clock; synchronous active-high reset
//   in_data/in_valid/in_ready - input stream; in_ready is combinational
//   mode, in_sel            - routing control (in_sel used only when mode=1)
//   a_data/a_valid/a_ready  - channel A output handshake
//   b_data/b_valid/b_ready  - channel B output handshake
//   busy                    - either channel holds an undelivered word
//   a_count/b_count         - 8-bit delivered-word counters (DMUX16_SCHED_COUNT_EN only)
//
// Optional feature macro: DMUX16_SCHED_COUNT_EN adds the per-channel counters.
module dmux16_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mode,
  input  logic        in_sel,
  output logic [15:0] a_data,
  output logic [15:0] b_data,
  output logic        a_valid,
  output logic        b_valid,
  input  logic        a_ready,
  input  logic        b_ready,
  output logic        busy
`ifdef DMUX16_SCHED_COUNT_EN
  ,
  output logic [7:0]  a_count,
  output logic [7:0]  b_count
`endif
);

  typedef enum logic {
    RrA = 1'b0,
    RrB = 1'b1
  } rr_e;

  rr_e         rr_q;
  logic [15:0] a_data_q, b_data_q;
  logic        a_valid_q, b_valid_q;

  logic target;     // 0 = channel A, 1 = channel B
  logic tgt_valid;
  logic tgt_ready;
  logic accept;
  logic load_a, load_b;
  logic a_hs, b_hs;

  always_comb begin
    target    = mode ? in_sel : (rr_q == RrB);
    tgt_valid = target ? b_valid_q : a_valid_q;
    tgt_ready = target ? b_ready : a_ready;
    // A full target with a stalled consumer blocks input even if the other channel is
    // empty: words are never skipped past the scheduled channel.
    in_ready  = !reset && (!tgt_valid || tgt_ready);
    accept    = in_valid && in_ready;
    load_a    = accept && !target;
    load_b    = accept && target;
    a_hs      = a_valid_q && a_ready;
    b_hs      = b_valid_q && b_ready;
  end

`ifdef DMUX16_SCHED_COUNT_EN
  logic [7:0] a_count_q, b_count_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q      <= RrA;
      a_data_q  <= 16'h0000;
      b_data_q  <= 16'h0000;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
`ifdef DMUX16_SCHED_COUNT_EN
      a_count_q <= 8'd0;
      b_count_q <= 8'd0;
`endif
    end else begin
      // A reload on the same edge as a handshake keeps valid high with new data.
      if (load_a) begin
        a_data_q  <= in_data;
        a_valid_q <= 1'b1;
      end else if (a_hs) begin
        a_valid_q <= 1'b0;
      end

      if (load_b) begin
        b_data_q  <= in_data;
        b_valid_q <= 1'b1;
      end else if (b_hs) begin
        b_valid_q <= 1'b0;
      end

      // Pointer only advances on round-robin accepts; steered traffic leaves it parked.
      if (accept && !mode) begin
        rr_q <= (rr_q == RrA) ? RrB : RrA;
      end

`ifdef DMUX16_SCHED_COUNT_EN
      if (a_hs) a_count_q <= a_count_q + 8'd1;
      if (b_hs) b_count_q <= b_count_q + 8'd1;
`endif
    end
  end

  assign a_data  = a_data_q;
  assign b_data  = b_data_q;
  assign a_valid = a_valid_q;
  assign b_valid = b_valid_q;
  assign busy    = a_valid_q || b_valid_q;

`ifdef DMUX16_SCHED_COUNT_EN
  assign a_count = a_count_q;
  assign b_count = b_count_q;
`endif

endmodule

// File: tb/tb_dmux16_sched.sv
// Directed, table-driven bench for dmux16_sched. Each vector sets the inputs just
// after a rising edge, checks the combinational in_ready, then checks the registered
// channel outputs just after the following edge.
module tb_dmux16_sched;

  logic        clk;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mode;
  logic        in_sel;
  logic [15:0] a_data;
  logic [15:0] b_data;
  logic        a_valid;
  logic        b_valid;
  logic        a_ready;
  logic        b_ready;
  logic        busy;
`ifdef DMUX16_SCHED_COUNT_EN
  logic [7:0]  a_count;
  logic [7:0]  b_count;
`endif

  dmux16_sched dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .in_sel   (in_sel),
    .a_data   (a_data),
    .b_data   (b_data),
    .a_valid  (a_valid),
    .b_valid  (b_valid),
    .a_ready  (a_ready),
    .b_ready  (b_ready),
    .busy     (busy)
`ifdef DMUX16_SCHED_COUNT_EN
    ,
    .a_count  (a_count),
    .b_count  (b_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] id;
    logic        md;
    logic        sel;
    logic        ar;
    logic        br;
    logic        e_rdy;
    logic        e_av;
    logic [15:0] e_ad;
    logic        e_bv;
    logic [15:0] e_bd;
  } vec_t;

  localparam int NumVec = 18;
  vec_t vecs [NumVec];

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic vec_t mk(input logic iv, input logic [15:0] id, input logic md,
                              input logic sel, input logic ar, input logic br,
                              input logic e_rdy, input logic e_av, input logic [15:0] e_ad,
                              input logic e_bv, input logic [15:0] e_bd);
    vec_t v;
    v.iv = iv; v.id = id; v.md = md; v.sel = sel; v.ar = ar; v.br = br;
    v.e_rdy = e_rdy; v.e_av = e_av; v.e_ad = e_ad; v.e_bv = e_bv; v.e_bd = e_bd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    in_valid = v.iv; in_data = v.id; mode = v.md; in_sel = v.sel;
    a_ready = v.ar; b_ready = v.br;
    #1;
    chk($sformatf("v%0d in_ready", idx), {15'd0, in_ready}, {15'd0, v.e_rdy});
    tick();
    chk($sformatf("v%0d a_valid", idx), {15'd0, a_valid}, {15'd0, v.e_av});
    chk($sformatf("v%0d a_data", idx), a_data, v.e_ad);
    chk($sformatf("v%0d b_valid", idx), {15'd0, b_valid}, {15'd0, v.e_bv});
    chk($sformatf("v%0d b_data", idx), b_data, v.e_bd);
    chk($sformatf("v%0d busy", idx), {15'd0, busy}, {15'd0, v.e_av | v.e_bv});
  endtask

  initial begin
    //           iv  data     md sel ar br  rdy  av  a_data   bv  b_data
    // Round-robin A,B,A with ready consumers
    vecs[0]  = mk(1, 16'h1111, 0, 0, 1, 1,  1,   1, 16'h1111, 0, 16'h0000);
    vecs[1]  = mk(1, 16'h2222, 0, 0, 1, 1,  1,   0, 16'h1111, 1, 16'h2222);
    vecs[2]  = mk(1, 16'h3333, 0, 0, 1, 1,  1,   1, 16'h3333, 0, 16'h2222);
    vecs[3]  = mk(0, 16'h0000, 0, 0, 1, 1,  1,   0, 16'h3333, 0, 16'h2222);
    // Steered to A with A's consumer stalled: no skipping to empty B
    vecs[4]  = mk(1, 16'hAAAA, 1, 0, 0, 1,  1,   1, 16'hAAAA, 0, 16'h2222);
    vecs[5]  = mk(1, 16'hBBBB, 1, 0, 0, 1,  0,   1, 16'hAAAA, 0, 16'h2222);
    vecs[6]  = mk(1, 16'hBBBB, 1, 0, 0, 1,  0,   1, 16'hAAAA, 0, 16'h2222);
    vecs[7]  = mk(1, 16'hBBBB, 1, 0, 1, 1,  1,   1, 16'hBBBB, 0, 16'h2222);
    vecs[8]  = mk(0, 16'h0000, 1, 0, 0, 1,  0,   1, 16'hBBBB, 0, 16'h2222);
    // Drain and reload on the same edge
    vecs[9]  = mk(1, 16'h0001, 1, 0, 1, 1,  1,   1, 16'h0001, 0, 16'h2222);
    vecs[10] = mk(1, 16'h0002, 1, 0, 1, 1,  1,   1, 16'h0002, 0, 16'h2222);
    vecs[11] = mk(0, 16'h0000, 1, 0, 1, 1,  1,   0, 16'h0002, 0, 16'h2222);
    // Pointer parked at B during three steered accepts, then resumes at B
    vecs[12] = mk(1, 16'h00C1, 1, 0, 1, 1,  1,   1, 16'h00C1, 0, 16'h2222);
    vecs[13] = mk(1, 16'h00C2, 1, 0, 1, 1,  1,   1, 16'h00C2, 0, 16'h2222);
    vecs[14] = mk(1, 16'h00C3, 1, 0, 1, 1,  1,   1, 16'h00C3, 0, 16'h2222);
    vecs[15] = mk(1, 16'h00D1, 0, 0, 1, 1,  1,   0, 16'h00C3, 1, 16'h00D1);
    // in_sel ignored in round-robin mode
    vecs[16] = mk(1, 16'h00D2, 0, 1, 1, 1,  1,   1, 16'h00D2, 0, 16'h00D1);
    // Steered to B, both consumers stalled: both channels end up full
    vecs[17] = mk(1, 16'h00E1, 1, 1, 0, 0,  1,   1, 16'h00D2, 1, 16'h00E1);

    // Reset for two cycles with in_valid high
    reset = 1'b1; in_valid = 1'b1; in_data = 16'h5555; mode = 1'b0; in_sel = 1'b0;
    a_ready = 1'b1; b_ready = 1'b1;
    #1;
    chk("reset in_ready", {15'd0, in_ready}, 16'd0);
    tick();
    tick();
    chk("reset in_ready held", {15'd0, in_ready}, 16'd0);
    chk("reset a_valid", {15'd0, a_valid}, 16'd0);
    chk("reset b_valid", {15'd0, b_valid}, 16'd0);
    chk("reset a_data", a_data, 16'h0000);
    chk("reset b_data", b_data, 16'h0000);
    chk("reset busy", {15'd0, busy}, 16'd0);
    reset = 1'b0;

    for (int i = 0; i < NumVec; i++) apply(vecs[i], i);

    // Reset with both channels full and an accept pending
    reset = 1'b1; in_valid = 1'b1; in_data = 16'h7777; a_ready = 1'b1; b_ready = 1'b1;
    #1;
    chk("mid reset in_ready", {15'd0, in_ready}, 16'd0);
    tick();
    chk("mid reset a_valid", {15'd0, a_valid}, 16'd0);
    chk("mid reset b_valid", {15'd0, b_valid}, 16'd0);
    chk("mid reset a_data", a_data, 16'h0000);
    chk("mid reset b_data", b_data, 16'h0000);
    reset = 1'b0;

    // Pointer back at A after reset (it was at B before)
    in_valid = 1'b1; in_data = 16'h0F0F; mode = 1'b0; in_sel = 1'b1;
    a_ready = 1'b0; b_ready = 1'b0;
    tick();
    chk("post reset rr a_valid", {15'd0, a_valid}, 16'd1);
    chk("post reset rr a_data", a_data, 16'h0F0F);
    chk("post reset rr b_valid", {15'd0, b_valid}, 16'd0);
    in_valid = 1'b0;

`ifdef DMUX16_SCHED_COUNT_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("count reset a", {8'd0, a_count}, 16'd0);
    chk("count reset b", {8'd0, b_count}, 16'd0);
    // 256 words steered to A, one per cycle; the last is delivered on the idle cycle
    mode = 1'b1; in_sel = 1'b0; a_ready = 1'b1; b_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_data = 16'(i);
      tick();
    end
    chk("count a before wrap", {8'd0, a_count}, 16'd255);
    in_valid = 1'b0;
    tick();
    chk("count a wrapped", {8'd0, a_count}, 16'd0);
    chk("count b idle", {8'd0, b_count}, 16'd0);
    chk("count a_valid drained", {15'd0, a_valid}, 16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmux16_sched.md
DMUX16_SCHED -- requirements
Module: dmux16_sched

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port in_data, input, 16 bits: word to be routed.
REQ-004 SHALL have port in_valid, input, 1 bit: in_data valid.
REQ-005 SHALL have port in_ready, output, 1 bit: block accepts in_data this cycle.
REQ-006 SHALL have port mode, input, 1 bit: 0 selects round-robin routing; 1 selects steered routing.
REQ-007 SHALL have port in_sel, input, 1 bit: steered target, 0 = channel A, 1 = channel B; ignored when mode=0.
REQ-008 SHALL have ports a_data and b_data, output, 16 bits each: channel holding registers.
REQ-009 SHALL have ports a_valid and b_valid, output, 1 bit each: channel register holds an undelivered word.
REQ-010 SHALL have ports a_ready and b_ready, input, 1 bit each: consumer accepts the word.
REQ-011 SHALL have port busy, output, 1 bit: a_valid OR b_valid.
REQ-012 SHALL have ports a_count and b_count, output, 8 bits each, present only under DMUX16_SCHED_COUNT_EN (REQ-027).

Function
REQ-013 SHALL compute target = in_sel when mode=1, and target = rr_ptr when mode=0.
REQ-014 SHALL drive in_ready = !tgt_valid OR (tgt_valid AND tgt_ready), where tgt_valid and tgt_ready belong to the target channel (combinational pass-through).
REQ-015 SHALL, on accept (in_valid AND in_ready), load in_data into the target channel register and set its valid at the next edge (latency 1 cycle).
REQ-016 SHALL clear a channel's valid on its handshake (x_valid AND x_ready) unless the same edge reloads that channel, in which case valid stays 1 and the data is replaced.
REQ-017 SHALL hold the non-target channel's register and valid unchanged except for its own handshake.
REQ-018 SHALL implement rr_ptr as a two-state FSM, RR_A (0) and RR_B (1): on accept with mode=0, RR_A->RR_B and RR_B->RR_A; otherwise hold.
REQ-019 SHALL keep rr_ptr unchanged while mode=1; on return to mode=0, resume from the held state.
REQ-020 SHALL apply a mode or in_sel change in the same cycle; a word already buffered is not moved.
REQ-021 SHALL, when the target is full and its consumer is not ready, hold in_ready=0 even if the other channel is empty (no reordering, no skipping).
REQ-022 SHALL sustain one word per cycle when consumers hold ready=1.
REQ-023 SHALL retain a_data and b_data values after delivery; they are valid only when the matching valid is 1.

Reset
REQ-024 SHALL, with reset=1 at an edge, set a_data=0, b_data=0, a_valid=0, b_valid=0, rr_ptr=RR_A, and counters=0.
REQ-025 SHALL force in_ready=0 while reset=1, and a reset mid-transfer SHALL discard buffered words.
REQ-026 SHALL give reset priority over every simultaneous accept or handshake.

Configuration
REQ-027 SHALL, with DMUX16_SCHED_COUNT_EN defined, provide a_count and b_count as 8-bit counters that increment on each A or B output handshake and wrap 255->0.
REQ-028 SHALL, without DMUX16_SCHED_COUNT_EN, omit a_count, b_count and their logic; all other behaviour SHALL be identical.

Verification
REQ-029 Reset: assert reset for 2 cycles with in_valid=1 -> a_valid=b_valid=0, in_ready=0, data=0x0000, rr_ptr=RR_A.
REQ-030 Round-robin: mode=0, both readies=1, send 0x1111, 0x2222, 0x3333 on consecutive cycles -> A gets 0x1111, B gets 0x2222, A gets 0x3333, each one cycle after accept.
REQ-031 Steered backpressure: mode=1, in_sel=0, a_ready=0, send 0xAAAA then 0xBBBB -> 0xAAAA held on A, in_ready=0, B stays empty; raise a_ready -> 0xBBBB accepted the same cycle and appears on A the next cycle.
REQ-032 Simultaneous drain and reload: a_valid=1 with 0x0001, a_ready=1, accept 0x0002 to A -> a_valid stays 1 and a_data=0x0002 the next cycle.
REQ-033 Mode switch and reset: mode=0 with rr_ptr=RR_B, switch to mode=1 for 3 accepts to A, return to mode=0 -> next word goes to B; assert reset with both channels full -> both valids=0 the next cycle.
REQ-034 Counters (macro on): deliver 256 words to A -> a_count wraps to 0 and b_count stays 0.
